// File: rtl/gcl_slot_sched.sv
// Slot scheduler for the NIC gate-control path.
// Splits time into slots of cfg_slot_len cycles, 16 slots per GCL entry, and prefetches
// the next entry from the GCL reader one slot ahead of the entry boundary.
// Build option: define SLOT_SCHED_ERR_HALT_EN to freeze in HALT on a prefetch miss;
// without it a miss only raises sched_err and the schedule keeps running.
module gcl_slot_sched #(
  parameter int unsigned SLOT_W  = 16,
  parameter int unsigned ENTRY_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SLOT_W-1:0]  cfg_slot_len,
  input  logic [ENTRY_W-1:0] cfg_entry_num,
  input  logic               lau_update_finish,
  input  logic               test_start,
  input  logic               test_stop,
  input  logic               gcl_rd_ack,
  output logic [3:0]         slot_shift_cnt,
  output logic               gcl_ram_rd,
  output logic [ENTRY_W-1:0] entry_idx,
  output logic               cycle_wrap,
  output logic               sched_active,
  output logic               sched_err
);

`ifdef SLOT_SCHED_ERR_HALT_EN
  localparam bit HaltEn = 1'b1;
`else
  localparam bit HaltEn = 1'b0;
`endif

  localparam logic [SLOT_W-1:0] MinLen = SLOT_W'(4);

  typedef enum logic [1:0] {StIdle, StPreload, StRun, StHalt} state_e;

  state_e             state_q, state_d;
  logic [SLOT_W-1:0]  len_q, len_d;
  logic [ENTRY_W:0]   num_q, num_d;      // one extra bit so 2^ENTRY_W fits
  logic [SLOT_W-1:0]  slot_cnt_q, slot_cnt_d;
  logic [3:0]         shift_q, shift_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic               pending_q, pending_d;
  logic               err_q, err_d;
  logic               rd_q, rd_d;
  logic               wrap_q, wrap_d;

  logic [SLOT_W-1:0]  len_clamp;
  logic [ENTRY_W:0]   num_clamp;
  logic [ENTRY_W:0]   entry_inc;
  logic               slot_last;
  logic               entry_last;
  logic               stop_req;
  logic               miss;

  assign len_clamp  = (cfg_slot_len < MinLen) ? MinLen : cfg_slot_len;
  assign num_clamp  = (cfg_entry_num == '0) ? {1'b1, {ENTRY_W{1'b0}}} : {1'b0, cfg_entry_num};
  assign entry_inc  = {1'b0, entry_q} + {{ENTRY_W{1'b0}}, 1'b1};
  assign entry_last = (entry_inc == num_q);
  assign slot_last  = (slot_cnt_q == len_q - SLOT_W'(1));
  assign stop_req   = test_stop | ~test_start;
  // An ack arriving in the boundary cycle itself still counts as on time.
  assign miss       = pending_q & ~gcl_rd_ack;

  // Next-state: start/preload handshake, slot and entry counting, prefetch tracking.
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    num_d      = num_q;
    slot_cnt_d = slot_cnt_q;
    shift_d    = shift_q;
    entry_d    = entry_q;
    pending_d  = pending_q;
    err_d      = err_q;
    rd_d       = 1'b0;
    wrap_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (lau_update_finish && test_start && !test_stop) begin
          state_d = StPreload;
          len_d   = len_clamp;
          num_d   = num_clamp;
          err_d   = 1'b0;
          rd_d    = 1'b1;
        end
      end
      StPreload: begin
        if (gcl_rd_ack) begin
          state_d    = StRun;
          slot_cnt_d = '0;
          shift_d    = '0;
          entry_d    = '0;
        end
      end
      StRun: begin
        if (pending_q && gcl_rd_ack) pending_d = 1'b0;
        if (!slot_last) begin
          slot_cnt_d = slot_cnt_q + SLOT_W'(1);
        end else if (shift_q != 4'd15) begin
          slot_cnt_d = '0;
          shift_d    = shift_q + 4'd1;
          // Entering the last slot: request the next entry now.
          if (shift_q == 4'd14) begin
            rd_d      = 1'b1;
            pending_d = 1'b1;
          end
        end else begin
          if (miss) begin
            err_d     = 1'b1;
            pending_d = 1'b0;
          end
          if (miss && HaltEn) begin
            state_d = StHalt;
          end else begin
            slot_cnt_d = '0;
            shift_d    = '0;
            entry_d    = entry_last ? '0 : entry_inc[ENTRY_W-1:0];
            wrap_d     = entry_last;
          end
        end
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: state_d = StIdle;
    endcase

    // Abort overrides everything, including a coincident entry boundary.
    if (state_q != StIdle && stop_req) begin
      state_d    = StIdle;
      slot_cnt_d = '0;
      shift_d    = '0;
      entry_d    = '0;
      pending_d  = 1'b0;
      err_d      = err_q;
      rd_d       = 1'b0;
      wrap_d     = 1'b0;
    end
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      len_q      <= MinLen;
      num_q      <= '0;
      slot_cnt_q <= '0;
      shift_q    <= '0;
      entry_q    <= '0;
      pending_q  <= 1'b0;
      err_q      <= 1'b0;
      rd_q       <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      num_q      <= num_d;
      slot_cnt_q <= slot_cnt_d;
      shift_q    <= shift_d;
      entry_q    <= entry_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
      rd_q       <= rd_d;
      wrap_q     <= wrap_d;
    end
  end

  assign slot_shift_cnt = shift_q;
  assign gcl_ram_rd     = rd_q;
  assign entry_idx      = entry_q;
  assign cycle_wrap     = wrap_q;
  assign sched_active   = (state_q == StRun);
  assign sched_err      = err_q;

endmodule
